// File: rtl/pool_window_gen_if.sv
// pool_window_gen_if: pixel-in / window-out stream bundle for the 2x2 pooling window generator.
// Optional WINGEN_POS_EN adds the pooled-coordinate outputs win_row / win_col.
// slave = window generator side, master = producer/consumer side.
interface pool_window_gen_if #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28
);
  localparam int PRW = (IMG_H / 2 > 1) ? $clog2(IMG_H / 2) : 1;
  localparam int PCW = (IMG_W / 2 > 1) ? $clog2(IMG_W / 2) : 1;

  logic [DATA_W-1:0] pix_in;
  logic              pix_valid;
  logic              pix_ready;
  logic [DATA_W-1:0] win1;
  logic [DATA_W-1:0] win2;
  logic [DATA_W-1:0] win3;
  logic [DATA_W-1:0] win4;
  logic              win_valid;
  logic              win_ready;
  logic              win_last;
`ifdef WINGEN_POS_EN
  logic [PRW-1:0]    win_row;
  logic [PCW-1:0]    win_col;

  modport slave (
    input  pix_in, pix_valid, win_ready,
    output pix_ready, win1, win2, win3, win4, win_valid, win_last, win_row, win_col
  );
  modport master (
    output pix_in, pix_valid, win_ready,
    input  pix_ready, win1, win2, win3, win4, win_valid, win_last, win_row, win_col
  );
`else
  modport slave (
    input  pix_in, pix_valid, win_ready,
    output pix_ready, win1, win2, win3, win4, win_valid, win_last
  );
  modport master (
    output pix_in, pix_valid, win_ready,
    input  pix_ready, win1, win2, win3, win4, win_valid, win_last
  );
`endif
endinterface

// File: rtl/pool_window_gen.sv
// pool_window_gen: raster pixel stream in, non-overlapping stride-2 2x2 windows out (TL,TR,BL,BR).
// Latency: window valid the cycle after its bottom-right pixel is accepted; 1 pixel/cycle sustained.
// Backpressure: single output register, pix_ready = !win_valid || win_ready. Macro WINGEN_POS_EN adds win_row/win_col.
module pool_window_gen #(
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int DATA_W = 8
) (
  input logic              clk,
  input logic              rst,
  pool_window_gen_if.slave bus
);
  localparam int CW  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW  = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int PRW = (IMG_H / 2 > 1) ? $clog2(IMG_H / 2) : 1;
  localparam int PCW = (IMG_W / 2 > 1) ? $clog2(IMG_W / 2) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  // Raster position of the next pixel to be accepted
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;

  // Top row of the current window pair and the pending bottom-left pixel
  logic [DATA_W-1:0] linebuf_q [IMG_W];
  logic [DATA_W-1:0] hold_q;

  // Output window register
  logic [DATA_W-1:0] win1_q, win1_d;
  logic [DATA_W-1:0] win2_q, win2_d;
  logic [DATA_W-1:0] win3_q, win3_d;
  logic [DATA_W-1:0] win4_q, win4_d;
  logic              win_vld_q, win_vld_d;
  logic              win_last_q, win_last_d;
`ifdef WINGEN_POS_EN
  logic [PRW-1:0]    win_row_q, win_row_d;
  logic [PCW-1:0]    win_col_q, win_col_d;
`endif

  logic pix_rdy;
  logic accept;
  logic consume;
  logic emit;

  assign pix_rdy = !win_vld_q || bus.win_ready;
  assign accept  = bus.pix_valid && pix_rdy;
  assign consume = win_vld_q && bus.win_ready;
  // Bottom-right pixel of a window: odd row, odd column
  assign emit    = accept && row_q[0] && col_q[0];

  // Next-state: advance raster position, retire consumed window, load a new one on bottom-right
  always_comb begin
    col_d      = col_q;
    row_d      = row_q;
    win1_d     = win1_q;
    win2_d     = win2_q;
    win3_d     = win3_q;
    win4_d     = win4_q;
    win_vld_d  = win_vld_q;
    win_last_d = win_last_q;
`ifdef WINGEN_POS_EN
    win_row_d  = win_row_q;
    win_col_d  = win_col_q;
`endif
    if (consume) begin
      win_vld_d  = 1'b0;
      win_last_d = 1'b0;
    end
    if (accept) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
    // A reload in the same cycle as a consume overrides the clear above
    if (emit) begin
      win1_d     = linebuf_q[col_q - 1'b1];
      win2_d     = linebuf_q[col_q];
      win3_d     = hold_q;
      win4_d     = bus.pix_in;
      win_vld_d  = 1'b1;
      win_last_d = (row_q == ROW_LAST) && (col_q == COL_LAST);
`ifdef WINGEN_POS_EN
      win_row_d  = PRW'(row_q >> 1);
      win_col_d  = PCW'(col_q >> 1);
`endif
    end
  end

  // Control and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q      <= '0;
      row_q      <= '0;
      win1_q     <= '0;
      win2_q     <= '0;
      win3_q     <= '0;
      win4_q     <= '0;
      win_vld_q  <= 1'b0;
      win_last_q <= 1'b0;
`ifdef WINGEN_POS_EN
      win_row_q  <= '0;
      win_col_q  <= '0;
`endif
    end else begin
      col_q      <= col_d;
      row_q      <= row_d;
      win1_q     <= win1_d;
      win2_q     <= win2_d;
      win3_q     <= win3_d;
      win4_q     <= win4_d;
      win_vld_q  <= win_vld_d;
      win_last_q <= win_last_d;
`ifdef WINGEN_POS_EN
      win_row_q  <= win_row_d;
      win_col_q  <= win_col_d;
`endif
    end
  end

  // Pixel storage: even rows fill the line buffer, odd-row even columns park the bottom-left pixel.
  // Contents are don't-care after reset, so no reset term here.
  always_ff @(posedge clk) begin
    if (accept && !row_q[0]) begin
      linebuf_q[col_q] <= bus.pix_in;
    end
    if (accept && row_q[0] && !col_q[0]) begin
      hold_q <= bus.pix_in;
    end
  end

  assign bus.pix_ready = pix_rdy;
  assign bus.win1      = win1_q;
  assign bus.win2      = win2_q;
  assign bus.win3      = win3_q;
  assign bus.win4      = win4_q;
  assign bus.win_valid = win_vld_q;
  assign bus.win_last  = win_last_q;
`ifdef WINGEN_POS_EN
  assign bus.win_row   = win_row_q;
  assign bus.win_col   = win_col_q;
`endif
endmodule

// File: tb/tb_pool_window_gen.sv
// Bench for pool_window_gen: a 4x4 instance for directed frames, a 6x6 instance for random gaps/stalls.
// A frame-level model (stored pixels, beat index -> (row,col)) predicts every output each cycle.
// Literal window tables pin the expected frame results; WINGEN_POS_EN also checks coordinates.
module tb_pool_window_gen;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b;

  pool_window_gen_if #(.DATA_W(8), .IMG_W(4), .IMG_H(4)) ia ();
  pool_window_gen_if #(.DATA_W(8), .IMG_W(6), .IMG_H(6)) ib ();

  pool_window_gen #(.IMG_W(4), .IMG_H(4), .DATA_W(8)) dut_a (.clk(clk), .rst(rst_a), .bus(ia.slave));
  pool_window_gen #(.IMG_W(6), .IMG_H(6), .DATA_W(8)) dut_b (.clk(clk), .rst(rst_b), .bus(ib.slave));

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  // Model state per instance (0 = 4x4, 1 = 6x6)
  bit         ev [2];
  logic [7:0] ew [2][4];
  bit         el [2];
  int         er [2];
  int         ec [2];
  int         nb [2];
  logic [7:0] frame [2][36];

  // Windows actually handed over by each DUT, plus accepted-pixel counts
  typedef struct {
    logic [7:0] w1, w2, w3, w4;
    logic       last;
    int         r, c;
  } win_t;
  win_t dlog [2][64];
  int   dn  [2];
  int   acc [2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: actual %0d required %0d", nm, act, exp);
    end
  endtask

  // Frame-level reference: pixel n sits at (n/W, n%W); odd/odd closes a window
  task automatic model_step(input int d, input int W, input int H, input logic r,
                            input logic pv, input logic [7:0] px, input logic wr);
    bit rdy;
    int rr, cc;
    if (r) begin
      ev[d] = 1'b0;
      el[d] = 1'b0;
      nb[d] = 0;
    end else begin
      rdy = !ev[d] || wr;
      if (ev[d] && wr) begin
        ev[d] = 1'b0;
        el[d] = 1'b0;
      end
      if (pv && rdy) begin
        frame[d][nb[d]] = px;
        rr = nb[d] / W;
        cc = nb[d] % W;
        if ((rr % 2 == 1) && (cc % 2 == 1)) begin
          ew[d][0] = frame[d][(rr - 1) * W + cc - 1];
          ew[d][1] = frame[d][(rr - 1) * W + cc];
          ew[d][2] = frame[d][rr * W + cc - 1];
          ew[d][3] = px;
          el[d] = (nb[d] == W * H - 1);
          er[d] = rr / 2;
          ec[d] = cc / 2;
          ev[d] = 1'b1;
        end
        nb[d] = (nb[d] == W * H - 1) ? 0 : nb[d] + 1;
      end
    end
  endtask

  task automatic capture(input int d, input logic [7:0] w1, input logic [7:0] w2,
                         input logic [7:0] w3, input logic [7:0] w4, input logic l,
                         input int r, input int c);
    if (dn[d] < 64) begin
      dlog[d][dn[d]].w1   = w1;
      dlog[d][dn[d]].w2   = w2;
      dlog[d][dn[d]].w3   = w3;
      dlog[d][dn[d]].w4   = w4;
      dlog[d][dn[d]].last = l;
      dlog[d][dn[d]].r    = r;
      dlog[d][dn[d]].c    = c;
      dn[d]++;
    end
  endtask

  task automatic cmp(input int d, input string nm, input logic pr, input logic wr,
                     input logic wv, input logic wl, input logic [7:0] w1, input logic [7:0] w2,
                     input logic [7:0] w3, input logic [7:0] w4, input int r, input int c);
    chk({nm, ".pix_ready"}, pr, (!ev[d] || wr));
    chk({nm, ".win_valid"}, wv, ev[d]);
    if (ev[d]) begin
      chk({nm, ".win1"}, w1, ew[d][0]);
      chk({nm, ".win2"}, w2, ew[d][1]);
      chk({nm, ".win3"}, w3, ew[d][2]);
      chk({nm, ".win4"}, w4, ew[d][3]);
      chk({nm, ".win_last"}, wl, el[d]);
`ifdef WINGEN_POS_EN
      chk({nm, ".win_row"}, r, er[d]);
      chk({nm, ".win_col"}, c, ec[d]);
`endif
    end
  endtask

  // Model update and DUT handshake logging on the active edge (pre-edge values)
  always @(posedge clk) begin
    int ra, ca, rb, cb;
    ra = 0; ca = 0; rb = 0; cb = 0;
`ifdef WINGEN_POS_EN
    ra = int'(ia.win_row); ca = int'(ia.win_col);
    rb = int'(ib.win_row); cb = int'(ib.win_col);
`endif
    if (!rst_a && ia.win_valid && ia.win_ready)
      capture(0, ia.win1, ia.win2, ia.win3, ia.win4, ia.win_last, ra, ca);
    if (!rst_b && ib.win_valid && ib.win_ready)
      capture(1, ib.win1, ib.win2, ib.win3, ib.win4, ib.win_last, rb, cb);
    if (!rst_a && ia.pix_valid && ia.pix_ready) acc[0]++;
    if (!rst_b && ib.pix_valid && ib.pix_ready) acc[1]++;
    model_step(0, 4, 4, rst_a, ia.pix_valid, ia.pix_in, ia.win_ready);
    model_step(1, 6, 6, rst_b, ib.pix_valid, ib.pix_in, ib.win_ready);
  end

  // Cycle-by-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    int ra, ca, rb, cb;
    ra = 0; ca = 0; rb = 0; cb = 0;
`ifdef WINGEN_POS_EN
    ra = int'(ia.win_row); ca = int'(ia.win_col);
    rb = int'(ib.win_row); cb = int'(ib.win_col);
`endif
    if (chk_en) begin
      cmp(0, "A", ia.pix_ready, ia.win_ready, ia.win_valid, ia.win_last,
          ia.win1, ia.win2, ia.win3, ia.win4, ra, ca);
      cmp(1, "B", ib.pix_ready, ib.win_ready, ib.win_valid, ib.win_last,
          ib.win1, ib.win2, ib.win3, ib.win4, rb, cb);
    end
  end

  task automatic send_a(input logic [7:0] v);
    bit ok;
    int g;
    g = 0;
    ia.pix_in = v;
    ia.pix_valid = 1'b1;
    do begin
      @(negedge clk);
      ok = ia.pix_ready;
      @(posedge clk);
      #1;
      g++;
    end while (!ok && g < 200);
    if (!ok) chk("send_a.timeout", 32'd0, 32'd1);
  endtask

  task automatic drain;
    repeat (4) @(posedge clk);
    #1;
  endtask

  // Four windows of a 4x4 frame whose pixels are off..off+15
  task automatic check_frame(input string nm, input int base, input int off);
    int tl [4];
    int t;
    tl = '{0, 2, 8, 10};
    for (int k = 0; k < 4; k++) begin
      t = tl[k] + off;
      chk({nm, ".w1"}, dlog[0][base + k].w1, t);
      chk({nm, ".w2"}, dlog[0][base + k].w2, t + 1);
      chk({nm, ".w3"}, dlog[0][base + k].w3, t + 4);
      chk({nm, ".w4"}, dlog[0][base + k].w4, t + 5);
      chk({nm, ".last"}, dlog[0][base + k].last, (k == 3));
`ifdef WINGEN_POS_EN
      chk({nm, ".row"}, dlog[0][base + k].r, k / 2);
      chk({nm, ".col"}, dlog[0][base + k].c, k % 2);
`endif
    end
  endtask

  initial begin
    int base;
    int a0;
    int g;
    bit ok;
    logic [7:0] px;

    ia.pix_in = '0; ia.pix_valid = 1'b0; ia.win_ready = 1'b1;
    ib.pix_in = '0; ib.pix_valid = 1'b0; ib.win_ready = 1'b1;
    rst_a = 1'b1;
    rst_b = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_a = 1'b0;
    rst_b = 1'b0;

    // Reset state
    chk("reset.win_valid", ia.win_valid, 0);
    chk("reset.win_last", ia.win_last, 0);
    chk("reset.pix_ready", ia.pix_ready, 1);
    chk("reset.win1", ia.win1, 0);
    chk("reset.win2", ia.win2, 0);
    chk("reset.win3", ia.win3, 0);
    chk("reset.win4", ia.win4, 0);
    chk("reset.b_win_valid", ib.win_valid, 0);
`ifdef WINGEN_POS_EN
    chk("reset.win_row", ia.win_row, 0);
    chk("reset.win_col", ia.win_col, 0);
`endif
    chk_en = 1'b1;

    // Frame 0..15 back-to-back, consumer always ready
    base = dn[0];
    for (int v = 0; v < 16; v++) begin
      send_a(8'(v));
      if (v == 4) chk("t1.no_window_yet", ia.win_valid, 0);
      if (v == 5) begin
        chk("t1.latency_valid", ia.win_valid, 1);
        chk("t1.first_w1", ia.win1, 0);
        chk("t1.first_w2", ia.win2, 1);
        chk("t1.first_w3", ia.win3, 4);
        chk("t1.first_w4", ia.win4, 5);
      end
    end
    ia.pix_valid = 1'b0;
    drain();
    chk("t1.count", dn[0] - base, 4);
    check_frame("t1", base, 0);

    // Same frame, consumer stalls 5 cycles on the first window
    base = dn[0];
    fork
      begin
        for (int v = 0; v < 16; v++) send_a(8'(v));
        ia.pix_valid = 1'b0;
      end
      begin
        g = 0;
        while (!ia.win_valid && g < 100) begin
          @(posedge clk);
          #1;
          g++;
        end
        chk("t2.window_seen", ia.win_valid, 1);
        ia.win_ready = 1'b0;
        a0 = acc[0];
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          chk("t2.pix_ready_low", ia.pix_ready, 0);
          chk("t2.w1_stable", ia.win1, 0);
          chk("t2.w4_stable", ia.win4, 5);
          chk("t2.valid_held", ia.win_valid, 1);
          @(posedge clk);
          #1;
        end
        chk("t2.no_input_taken", acc[0] - a0, 0);
        ia.win_ready = 1'b1;
      end
    join
    drain();
    chk("t2.count", dn[0] - base, 4);
    check_frame("t2", base, 0);

    // Reset after pixel 9, then a fresh frame
    for (int v = 0; v < 10; v++) send_a(8'(v));
    ia.pix_valid = 1'b0;
    rst_a = 1'b1;
    @(posedge clk);
    #1;
    rst_a = 1'b0;
    chk("t3.valid_after_rst", ia.win_valid, 0);
    chk("t3.last_after_rst", ia.win_last, 0);
    chk("t3.ready_after_rst", ia.pix_ready, 1);
    base = dn[0];
    for (int v = 0; v < 16; v++) send_a(8'(v));
    ia.pix_valid = 1'b0;
    drain();
    chk("t3.count", dn[0] - base, 4);
    check_frame("t3", base, 0);

    // Two frames with no gap
    base = dn[0];
    for (int v = 0; v < 16; v++) send_a(8'(v));
    for (int v = 0; v < 16; v++) send_a(8'(100 + v));
    ia.pix_valid = 1'b0;
    drain();
    chk("t4.count", dn[0] - base, 8);
    check_frame("t4a", base, 0);
    check_frame("t4b", base + 4, 100);

    // 6x6 with random input gaps and random consumer stalls
    base = dn[1];
    for (int i = 0; i < 36; i++) begin
      px = 8'($urandom_range(0, 255));
      ok = 1'b0;
      g = 0;
      while (!ok && g < 200) begin
        ib.pix_in = px;
        ib.pix_valid = ($urandom_range(0, 1) == 1);
        ib.win_ready = ($urandom_range(0, 3) != 0);
        @(negedge clk);
        ok = ib.pix_valid && ib.pix_ready;
        @(posedge clk);
        #1;
        g++;
      end
      if (!ok) chk("t5.send_timeout", 32'd0, 32'd1);
    end
    ib.pix_valid = 1'b0;
    ib.win_ready = 1'b1;
    drain();
    chk("t5.count", dn[1] - base, 9);
    for (int k = 0; k < 9; k++) begin
      chk("t5.last", dlog[1][base + k].last, (k == 8));
`ifdef WINGEN_POS_EN
      chk("t5.row", dlog[1][base + k].r, k / 3);
      chk("t5.col", dlog[1][base + k].c, k % 3);
`endif
    end

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
